// File: rtl/seg_scroll_display.sv
// Eight-digit multiplexed seven-segment driver fed by a scrolling character command stream.
// Holds the digits in a shift register and scans them onto shared active-low anode/cathode pins.
module seg_scroll_display #(
    parameter real CLK_FREQ     = 100.0,
    parameter real REFRESH_RATE = 100.0,
    parameter int  NUM_DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            seg_data,
    input  logic                  seg_off,
    input  logic                  seg_shift,
    input  logic                  seg_write,
    input  logic                  seg_clear,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [7:0]            cathodes
);

    localparam int DIGIT_CYCLES = int'(CLK_FREQ * 1.0e6 / (REFRESH_RATE * NUM_DIGITS));
    localparam int CNT_W        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [4:0]       BLANK    = 5'h10;

    generate
        if (DIGIT_CYCLES < 1) begin : g_bad_cycles
            $error("seg_scroll_display: DIGIT_CYCLES must be at least 1");
        end
        if (NUM_DIGITS != 8) begin : g_bad_digits
            $error("seg_scroll_display: NUM_DIGITS must be 8");
        end
    endgenerate

    // Each digit is {blank, val[3:0]}; digit 0 is the rightmost position.
    logic [4:0]            digit_p0 [NUM_DIGITS];
    logic [CNT_W-1:0]      cnt_p0;
    logic [2:0]            scan_idx_p0;
    logic [4:0]            cur_digit;
    logic [NUM_DIGITS-1:0] anodes_p1;
    logic [7:0]            cathodes_p1;

    assign cur_digit = digit_p0[scan_idx_p0];
    assign anodes    = anodes_p1;
    assign cathodes  = cathodes_p1;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_DIGITS; k++) digit_p0[k] <= BLANK;
            cnt_p0      <= '0;
            scan_idx_p0 <= '0;
            anodes_p1   <= '1;
            cathodes_p1 <= '1;
        end else begin
            if (cnt_p0 == CNT_LAST) begin
                cnt_p0      <= '0;
                scan_idx_p0 <= scan_idx_p0 + 3'd1;
            end else begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end

            // Clear overrides everything; shift then write forms the normal scroll step.
            if (seg_clear) begin
                for (int k = 0; k < NUM_DIGITS; k++) digit_p0[k] <= BLANK;
            end else begin
                if (seg_shift) begin
                    for (int k = 1; k < NUM_DIGITS; k++) digit_p0[k] <= digit_p0[k-1];
                    digit_p0[0] <= BLANK;
                end
                if (seg_write) digit_p0[0] <= {seg_off, seg_data};
            end

            // p0 -> p1: drive pins from the digit currently under the scan index.
            if (cur_digit[4]) begin
                anodes_p1   <= '1;
                cathodes_p1 <= '1;
            end else begin
                anodes_p1   <= ~(NUM_DIGITS'(1) << scan_idx_p0);
                cathodes_p1 <= seg_decode(cur_digit[3:0]);
            end
        end
    end

endmodule

// File: tb/tb_seg_scroll_display.sv
// Bench for seg_scroll_display: directed scroll scenarios plus random command traffic,
// checked every cycle against a queue-based display model.
module tb_seg_scroll_display;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] seg_data = '0;
    logic       seg_off = 1'b0;
    logic       seg_shift = 1'b0;
    logic       seg_write = 1'b0;
    logic       seg_clear = 1'b0;
    logic [7:0] anodes;
    logic [7:0] cathodes;

    int total = 0;
    int bad   = 0;

    seg_scroll_display #(.CLK_FREQ(1.0), .REFRESH_RATE(31250.0), .NUM_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .seg_data(seg_data), .seg_off(seg_off),
        .seg_shift(seg_shift), .seg_write(seg_write), .seg_clear(seg_clear),
        .anodes(anodes), .cathodes(cathodes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digits as a queue (index 0 = rightmost), scan slot from elapsed cycles.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [4:0] m_q [$];
    int         m_n = 0;
    bit         m_valid = 0;
    logic [7:0] exp_an = 8'hFF;
    logic [7:0] exp_ca = 8'hFF;

    always @(posedge clk) begin
        int idx;
        if (rst) begin
            m_q = {};
            repeat (8) m_q.push_back(5'h10);
            m_n = 0;
            exp_an = 8'hFF;
            exp_ca = 8'hFF;
            m_valid = 1;
        end else if (m_valid) begin
            idx = (m_n / DC) % 8;
            if (m_q[idx][4]) begin
                exp_an = 8'hFF;
                exp_ca = 8'hFF;
            end else begin
                exp_an = ~(8'h01 << idx);
                exp_ca = seg_tab[m_q[idx][3:0]];
            end
            m_n++;
            if (seg_clear) begin
                for (int k = 0; k < 8; k++) m_q[k] = 5'h10;
            end else begin
                if (seg_shift) begin
                    m_q.push_front(5'h10);
                    void'(m_q.pop_back());
                end
                if (seg_write) m_q[0] = {seg_off, seg_data};
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("anodes", 32'(anodes), 32'(exp_an));
            chk("cathodes", 32'(cathodes), 32'(exp_ca));
            chk("scan_idx", 32'(dut.scan_idx_p0), 32'((m_n / DC) % 8));
            chk("counter", 32'(dut.cnt_p0), 32'(m_n % DC));
            chk("one_anode", 32'($countones(~anodes) <= 1), 32'd1);
        end
    end

    task automatic drive(input logic c, input logic s, input logic w, input logic o,
                         input logic [3:0] d);
        @(posedge clk);
        #1;
        seg_clear = c;
        seg_shift = s;
        seg_write = w;
        seg_off   = o;
        seg_data  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [7:0] log_an [32];
    logic [7:0] log_ca [32];

    task automatic grab_frame();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            log_an[i] = anodes;
            log_ca[i] = cathodes;
        end
    endtask

    function automatic int hits(input logic [7:0] an, input logic [7:0] ca);
        int c = 0;
        for (int i = 0; i < 32; i++) if (log_an[i] == an && log_ca[i] == ca) c++;
        return c;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: nothing lit for two full frames.
        grab_frame();
        chk("idle_frame0_blank", 32'(hits(8'hFF, 8'hFF)), 32'd32);
        grab_frame();
        chk("idle_frame1_blank", 32'(hits(8'hFF, 8'hFF)), 32'd32);

        // Single write of 1 into digit 0.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
        idle();
        grab_frame();
        chk("write1_lit", 32'(hits(8'hFE, 8'hF9)), 32'd4);
        chk("write1_dark", 32'(hits(8'hFF, 8'hFF)), 32'd28);

        // Scroll 1,2,3 with combined shift+write pulses.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        idle();
        grab_frame();
        chk("scroll_d2", 32'(hits(8'hFB, 8'hF9)), 32'd4);
        chk("scroll_d1", 32'(hits(8'hFD, 8'hA4)), 32'd4);
        chk("scroll_d0", 32'(hits(8'hFE, 8'hB0)), 32'd4);
        chk("scroll_dark", 32'(hits(8'hFF, 8'hFF)), 32'd20);

        // Nine back-to-back scroll steps: A falls off the left end.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
        for (int v = 1; v <= 8; v++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'(v));
        idle();
        grab_frame();
        chk("nine_d7", 32'(hits(8'h7F, 8'hF9)), 32'd4);
        chk("nine_d6", 32'(hits(8'hBF, 8'hA4)), 32'd4);
        chk("nine_d0", 32'(hits(8'hFE, 8'h80)), 32'd4);
        chk("nine_no_A", 32'(hits(8'h7F, 8'h88)), 32'd0);
        chk("nine_dark", 32'(hits(8'hFF, 8'hFF)), 32'd0);

        // Clear wins over a simultaneous shift+write.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
        idle();
        grab_frame();
        chk("clear_blank", 32'(hits(8'hFF, 8'hFF)), 32'd32);

        // Visible 5, then a blanked write of F over it.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
        idle();
        grab_frame();
        chk("write5_lit", 32'(hits(8'hFE, 8'h92)), 32'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
        idle();
        grab_frame();
        chk("off_write_blank", 32'(hits(8'hFF, 8'hFF)), 32'd32);

        // Reset mid-frame with digits loaded.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h7);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h9);
        idle();
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_anodes", 32'(anodes), 32'hFF);
        chk("rst_cathodes", 32'(cathodes), 32'hFF);
        chk("rst_counter", 32'(dut.cnt_p0), 32'd0);
        rst = 1'b0;
        grab_frame();
        chk("rst_digits_blank", 32'(hits(8'hFF, 8'hFF)), 32'd32);

        // Random command traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 299) == 0);
            seg_clear = ($urandom_range(0, 39) == 0);
            seg_shift = ($urandom_range(0, 3) == 0);
            seg_write = ($urandom_range(0, 2) == 0);
            seg_off   = ($urandom_range(0, 4) == 0);
            seg_data  = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
